// File: rtl/dac_spi_frame_driver_if.sv
// Sample inputs and SPI/DAC control outputs of the DAC frame driver.
// master is the driver's view; slave is the view of whatever feeds and observes it.
interface dac_spi_frame_driver_if;
  logic [11:0] Va;
  logic [11:0] Vb;
  logic        start_enable;
  logic        SPI_SCK;
  logic        SPI_MOSI;
  logic        DAC_CS;
  logic        DAC_CLR;
  logic        dac_number;
  logic        frame_done;
  logic        busy;

  modport master (
    input  Va, Vb, start_enable,
    output SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR, dac_number, frame_done, busy
  );

  modport slave (
    output Va, Vb, start_enable,
    input  SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR, dac_number, frame_done, busy
  );
endinterface

// File: rtl/dac_spi_frame_driver.sv
// Serialises alternating channel A/B 12-bit samples into 32-bit write-and-update
// SPI frames for an LTC2624-style quad DAC.
module dac_spi_frame_driver #(
  parameter int unsigned SCK_HALF = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter logic [3:0]  CMD      = 4'b0011,
  parameter logic [3:0]  ADDR_A   = 4'b0000,
  parameter logic [3:0]  ADDR_B   = 4'b0001
) (
  input logic                    CLK_50M,
  input logic                    RST,
  dac_spi_frame_driver_if.master bus
);

  localparam int unsigned DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TAIL  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [5:0]       bit_q, bit_d;
  logic [31:0]      shreg_q, shreg_d;
  logic             chan_q, chan_d;
  logic             sck_q, sck_d;
  logic             cs_q, cs_d;
  logic             clr_q, clr_d;
  logic             dacn_q, dacn_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [31:0]      load_word;

  assign load_word = chan_q ? {8'h00, CMD, ADDR_B, bus.Vb, 4'h0}
                            : {8'h00, CMD, ADDR_A, bus.Va, 4'h0};

  // Next-state and next-output logic; MOSI is the shift register MSB, which
  // drains to zero after the last bit so the tail and gap idle low.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    chan_d  = chan_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    clr_d   = 1'b1;
    dacn_d  = dacn_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_enable && clr_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        shreg_d = load_word;
        cs_d    = 1'b0;
        busy_d  = 1'b1;
        sck_d   = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling SCK: present the next bit while the clock is low.
            sck_d   = 1'b0;
            shreg_d = {shreg_q[30:0], 1'b0};
            if (bit_q == 6'd31) state_d = S_TAIL;
            else                bit_d   = bit_q + 6'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_TAIL: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dacn_d  = chan_q;
          chan_d  = ~chan_q;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      chan_q  <= 1'b0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      clr_q   <= 1'b0;
      dacn_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      chan_q  <= chan_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      clr_q   <= clr_d;
      dacn_q  <= dacn_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.SPI_SCK    = sck_q;
  assign bus.SPI_MOSI   = shreg_q[31];
  assign bus.DAC_CS     = cs_q;
  assign bus.DAC_CLR    = clr_q;
  assign bus.dac_number = dacn_q;
  assign bus.frame_done = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dac_spi_frame_driver.sv
// Scoreboard bench: two drivers (default timing and SCK_HALF=1/CS_GAP=1) decoded
// from their SPI pins and compared against frames predicted from the sample inputs.
module tb_dac_spi_frame_driver;

  localparam int unsigned H0 = 2;
  localparam int unsigned G0 = 4;
  localparam int unsigned H1 = 1;
  localparam int unsigned G1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic        en   [2];
  logic [11:0] va   [2];
  logic [11:0] vb   [2];
  logic        sck  [2];
  logic        mosi [2];
  logic        cs   [2];
  logic        clr  [2];
  logic        dacn [2];
  logic        done [2];
  logic        busy [2];

  dac_spi_frame_driver_if if0 ();
  dac_spi_frame_driver_if if1 ();

  assign if0.Va = va[0];
  assign if0.Vb = vb[0];
  assign if0.start_enable = en[0];
  assign if1.Va = va[1];
  assign if1.Vb = vb[1];
  assign if1.start_enable = en[1];
  assign sck[0]  = if0.SPI_SCK;
  assign mosi[0] = if0.SPI_MOSI;
  assign cs[0]   = if0.DAC_CS;
  assign clr[0]  = if0.DAC_CLR;
  assign dacn[0] = if0.dac_number;
  assign done[0] = if0.frame_done;
  assign busy[0] = if0.busy;
  assign sck[1]  = if1.SPI_SCK;
  assign mosi[1] = if1.SPI_MOSI;
  assign cs[1]   = if1.DAC_CS;
  assign clr[1]  = if1.DAC_CLR;
  assign dacn[1] = if1.dac_number;
  assign done[1] = if1.frame_done;
  assign busy[1] = if1.busy;

  dac_spi_frame_driver #(.SCK_HALF(H0), .CS_GAP(G0)) u_dut0 (
    .CLK_50M(clk), .RST(rst[0]), .bus(if0)
  );
  dac_spi_frame_driver #(.SCK_HALF(H1), .CS_GAP(G1)) u_dut1 (
    .CLK_50M(clk), .RST(rst[1]), .bus(if1)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int starts [2];
  int ends   [2];
  int rises  [2];
  int perr   [2];
  logic chm  [2];
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  function automatic int hp(input int d);
    return (d == 0) ? int'(H0) : int'(H1);
  endfunction

  function automatic int gp(input int d);
    return (d == 0) ? int'(G0) : int'(G1);
  endfunction

  function automatic logic [31:0] exp_word(input logic c, input logic [11:0] s);
    return {8'h00, 4'b0011, (c ? 4'b0001 : 4'b0000), s, 4'h0};
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, want %h", name, d, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame for the channel the driver will send next.
  task automatic push(input int d);
    logic [32:0] e;
    e = {chm[d], exp_word(chm[d], chm[d] ? vb[d] : va[d])};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    chm[d] = ~chm[d];
  endtask

  task automatic flush(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
    chm[d] = 1'b0;
  endtask

  task automatic wait_starts(input int d, input int target);
    for (int i = 0; i < 4000 && starts[d] < target; i++) tick();
    check("frame start wait", d, 32'(starts[d] >= target), 32'd1);
  endtask

  task automatic wait_rises(input int d, input int target);
    for (int i = 0; i < 4000 && rises[d] < target; i++) tick();
    check("sck edge wait", d, 32'(rises[d] >= target), 32'd1);
  endtask

  task automatic wait_ends(input int d, input int target);
    for (int i = 0; i < 4000 && ends[d] < target; i++) tick();
    check("frame end wait", d, 32'(ends[d] >= target), 32'd1);
  endtask

  // One frame: predict it, let it start, then change samples mid-frame.
  task automatic frame(input int d, input int nedge, input logic [11:0] nva,
                       input logic [11:0] nvb, input bit last);
    int s0, r0, e0, s1;
    s0 = starts[d];
    push(d);
    en[d] = 1'b1;
    wait_starts(d, s0 + 1);
    r0 = rises[d];
    wait_rises(d, r0 + nedge);
    va[d] = nva;
    vb[d] = nvb;
    if (last) begin
      e0 = ends[d];
      en[d] = 1'b0;
      wait_ends(d, e0 + 1);
      s1 = starts[d];
      repeat (1000) tick();
      check("no restart", d, 32'(starts[d]), 32'(s1));
    end
  endtask

  task automatic reset_pulse(input int d, input int n);
    rst[d] = 1'b1;
    en[d]  = 1'b0;
    repeat (n) tick();
    flush(d);
    rst[d] = 1'b0;
  endtask

  task automatic reset_mid(input int d);
    int s0, r0;
    s0 = starts[d];
    push(d);
    en[d] = 1'b1;
    wait_starts(d, s0 + 1);
    r0 = rises[d];
    wait_rises(d, r0 + 10);
    rst[d] = 1'b1;
    flush(d);
    repeat (2) tick();
    rst[d] = 1'b0;
  endtask

  task automatic run(input int d);
    reset_pulse(d, 3);
    va[d] = 12'hABC;
    vb[d] = 12'h123;
    frame(d, 20, 12'h555, 12'h123, 1'b0);
    frame(d, 20, 12'h555, 12'h123, 1'b0);
    frame(d, 10, 12'hFFF, 12'h000, 1'b0);
    frame(d, 10, 12'hFFF, 12'h000, 1'b0);
    for (int i = 0; i < 6; i++)
      frame(d, int'($urandom_range(1, 31)), 12'($urandom), 12'($urandom), 1'b0);
    reset_mid(d);
    frame(d, 15, 12'($urandom), 12'($urandom), 1'b0);
    frame(d, 5, va[d], vb[d], 1'b1);
    check("protocol", d, 32'(perr[d]), 32'd0);
    check("leftover frames", d, 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  // Decodes the SPI pins of one driver and scores each completed frame.
  task automatic mon(input int d);
    logic r, fall, rise, prev_cs, prev_sck, prev_mosi, in_frame, have_gap, got;
    logic [31:0] word;
    logic [32:0] e;
    int nbits, low_cnt, high_cnt, since;
    prev_cs = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0;
    in_frame = 1'b0; have_gap = 1'b0; word = '0;
    nbits = 0; low_cnt = 0; high_cnt = 0; since = 0;
    forever begin
      @(posedge clk);
      r = rst[d];
      @(negedge clk);
      if (r) begin
        check("reset outputs", d,
              32'({cs[d], sck[d], mosi[d], busy[d], clr[d], done[d], dacn[d]}), 32'h40);
        in_frame = 1'b0;
        have_gap = 1'b0;
      end else begin
        fall = prev_cs && !cs[d];
        rise = !prev_cs && cs[d];
        if (!clr[d]) perr[d]++;
        if (busy[d] == cs[d]) perr[d]++;
        if (done[d] && !(rise && in_frame)) perr[d]++;
        if (fall) begin
          starts[d]++;
          if (have_gap) check("cs high gap", d, 32'(high_cnt >= gp(d) + 2), 32'd1);
          in_frame = 1'b1; word = '0; nbits = 0; low_cnt = 0; since = 0;
        end
        if (!cs[d]) begin
          low_cnt++;
          since++;
          if (sck[d] && !prev_sck) begin
            word = {word[30:0], mosi[d]};
            nbits++;
            rises[d]++;
            if (mosi[d] != prev_mosi) perr[d]++;
            if (nbits > 1 && since != 2 * hp(d)) perr[d]++;
            since = 0;
          end else if (sck[d] && prev_sck && mosi[d] != prev_mosi) begin
            perr[d]++;
          end
        end else begin
          high_cnt++;
          if (sck[d] || mosi[d]) perr[d]++;
        end
        if (rise) begin
          high_cnt = 1;
          if (in_frame) begin
            ends[d]++;
            got = 1'b0;
            e = '0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            check("frame expected", d, 32'(got), 32'd1);
            check("frame word", d, word, e[31:0]);
            check("bit count", d, 32'(nbits), 32'd32);
            check("cs low cycles", d, 32'(low_cnt), 32'(65 * hp(d)));
            check("frame_done", d, 32'(done[d]), 32'd1);
            check("dac_number", d, 32'(dacn[d]), 32'(e[32]));
            check("frame protocol", d, 32'(perr[d]), 32'd0);
            perr[d] = 0;
            have_gap = 1'b1;
          end
          in_frame = 1'b0;
        end
      end
      prev_cs = cs[d];
      prev_sck = sck[d];
      prev_mosi = mosi[d];
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      en[d] = 1'b0;
      va[d] = '0;
      vb[d] = '0;
      starts[d] = 0;
      ends[d] = 0;
      rises[d] = 0;
      perr[d] = 0;
      chm[d] = 1'b0;
    end
    fork
      mon(0);
      mon(1);
    join_none
    fork
      run(0);
      run(1);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
